// File: rtl/control_unit_decoder_pkg.sv
// ============================================================================
// rv_pkg : RV32I opcodes, funct3 values and decoder control encodings.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SLL    = 4'b0001,
    ALU_SLT    = 4'b0010,
    ALU_SLTU   = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SRL    = 4'b0101,
    ALU_OR     = 4'b0110,
    ALU_AND    = 4'b0111,
    ALU_SUB    = 4'b1000,
    ALU_PASS_B = 4'b1001,
    ALU_SRA    = 4'b1101
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_U = 3'b010,
    IMM_B = 3'b101,
    IMM_J = 3'b110
  } imm_src_e;

  typedef enum logic [4:0] {
    BR_NONE = 5'b00000,
    BR_JUMP = 5'b10000
  } br_op_e;

  // Conditional branches carry Funct3 in the low bits under this tag.
  localparam logic [1:0] BR_COND_TAG = 2'b01;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_src_e;

  typedef enum logic [1:0] {
    ALU_CLS_ADD    = 2'b00,
    ALU_CLS_R      = 2'b01,
    ALU_CLS_I      = 2'b10,
    ALU_CLS_PASS_B = 2'b11
  } alu_cls_e;

  typedef struct packed {
    logic       ru_wr;
    logic       alu_a_src;
    logic       alu_b_src;
    logic [3:0] alu_op;
    logic [2:0] imm_src;
    logic [4:0] br_op;
    logic       dm_wr;
    logic [2:0] dm_ctrl;
    logic [1:0] wb_src;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

`default_nettype wire

// File: rtl/control_unit_decoder_if.sv
// ============================================================================
// control_unit_decoder_if : instruction fields in, datapath controls out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface control_unit_decoder_if;

  logic [6:0] OpCode;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic       RUWr;
  logic       ALUASrc;
  logic       ALUBSrc;
  logic [3:0] ALUOp;
  logic [2:0] ImmSrc;
  logic [4:0] BrOp;
  logic       DMWr;
  logic [2:0] DMCtrl;
  logic [1:0] RUDataWrSrc;
  logic       IllegalInstr;
  logic       IllegalSeen;

  modport master (
    output OpCode, Funct3, Funct7,
    input  RUWr, ALUASrc, ALUBSrc, ALUOp, ImmSrc, BrOp, DMWr, DMCtrl,
           RUDataWrSrc, IllegalInstr, IllegalSeen
  );

  modport slave (
    input  OpCode, Funct3, Funct7,
    output RUWr, ALUASrc, ALUBSrc, ALUOp, ImmSrc, BrOp, DMWr, DMCtrl,
           RUDataWrSrc, IllegalInstr, IllegalSeen
  );

endinterface

`default_nettype wire

// File: rtl/control_unit_decoder_alu_decoder.sv
// ============================================================================
// alu_decoder : ALU operation from opcode class, Funct3 and Funct7[5].
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
  import rv_pkg::*;
(
  input  alu_cls_e   alu_cls_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_b5_i,
  output logic [3:0] alu_op_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    case (alu_cls_i)
      ALU_CLS_R:      alu_op_o = {funct7_b5_i, funct3_i};
      // Only shifts look at Funct7[5]; ADDI with imm[10]=1 stays ADD.
      ALU_CLS_I:      alu_op_o = (funct3_i == F3_SRL_SRA) ? {funct7_b5_i, funct3_i}
                                                          : {1'b0, funct3_i};
      ALU_CLS_PASS_B: alu_op_o = ALU_PASS_B;
      default:        alu_op_o = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_unit_decoder.sv
// ============================================================================
// control_unit_decoder : RV32I main decoder with sticky illegal-opcode flag.
// Optional output register stage enabled by macro CU_OUTPUT_REG_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit_decoder
  import rv_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  control_unit_decoder_if.slave  cu
);

  alu_cls_e   w_alu_cls;
  logic [3:0] w_alu_op;
  ctrl_t      ctrl_d;
  ctrl_t      w_ctrl_out;
  logic       illegal_seen_d;
  logic       illegal_seen_q;
  logic       w_unused_funct7;

  assign w_unused_funct7 = ^{cu.Funct7[6], cu.Funct7[4:0]};

  always_comb begin
    w_alu_cls = ALU_CLS_ADD;
    case (cu.OpCode)
      OP_R:     w_alu_cls = ALU_CLS_R;
      OP_I_ALU: w_alu_cls = ALU_CLS_I;
      OP_LUI:   w_alu_cls = ALU_CLS_PASS_B;
      default:  w_alu_cls = ALU_CLS_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_cls_i   (w_alu_cls),
    .funct3_i    (cu.Funct3),
    .funct7_b5_i (cu.Funct7[5]),
    .alu_op_o    (w_alu_op)
  );

  always_comb begin
    ctrl_d        = CTRL_NOP;
    ctrl_d.alu_op = w_alu_op;
    case (cu.OpCode)
      OP_R: begin
        ctrl_d.ru_wr = 1'b1;
      end
      OP_I_ALU: begin
        ctrl_d.ru_wr     = 1'b1;
        ctrl_d.alu_b_src = 1'b1;
      end
      OP_LOAD: begin
        ctrl_d.ru_wr     = 1'b1;
        ctrl_d.alu_b_src = 1'b1;
        ctrl_d.imm_src   = IMM_I;
        ctrl_d.dm_ctrl   = cu.Funct3;
        ctrl_d.wb_src    = WB_MEM;
      end
      OP_STORE: begin
        ctrl_d.alu_b_src = 1'b1;
        ctrl_d.imm_src   = IMM_S;
        ctrl_d.dm_wr     = 1'b1;
        ctrl_d.dm_ctrl   = cu.Funct3;
      end
      OP_BRANCH: begin
        ctrl_d.alu_a_src = 1'b1;
        ctrl_d.alu_b_src = 1'b1;
        ctrl_d.imm_src   = IMM_B;
        ctrl_d.br_op     = {BR_COND_TAG, cu.Funct3};
      end
      OP_JALR: begin
        ctrl_d.ru_wr     = 1'b1;
        ctrl_d.alu_b_src = 1'b1;
        ctrl_d.imm_src   = IMM_I;
        ctrl_d.br_op     = BR_JUMP;
        ctrl_d.wb_src    = WB_PC4;
      end
      OP_JAL: begin
        ctrl_d.ru_wr     = 1'b1;
        ctrl_d.alu_a_src = 1'b1;
        ctrl_d.alu_b_src = 1'b1;
        ctrl_d.imm_src   = IMM_J;
        ctrl_d.br_op     = BR_JUMP;
        ctrl_d.wb_src    = WB_PC4;
      end
      OP_LUI: begin
        ctrl_d.ru_wr     = 1'b1;
        ctrl_d.alu_b_src = 1'b1;
        ctrl_d.imm_src   = IMM_U;
      end
      OP_AUIPC: begin
        ctrl_d.ru_wr     = 1'b1;
        ctrl_d.alu_a_src = 1'b1;
        ctrl_d.alu_b_src = 1'b1;
        ctrl_d.imm_src   = IMM_U;
      end
      default: begin
        // Unsupported opcode degrades to a NOP so no architectural state changes.
        ctrl_d         = CTRL_NOP;
        ctrl_d.illegal = 1'b1;
      end
    endcase
  end

`ifdef CU_OUTPUT_REG_EN
  ctrl_t ctrl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= CTRL_NOP;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign w_ctrl_out = ctrl_q;
`else
  assign w_ctrl_out = ctrl_d;
`endif

  assign illegal_seen_d = illegal_seen_q | w_ctrl_out.illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_seen_q <= 1'b0;
    end else begin
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign cu.RUWr         = w_ctrl_out.ru_wr;
  assign cu.ALUASrc      = w_ctrl_out.alu_a_src;
  assign cu.ALUBSrc      = w_ctrl_out.alu_b_src;
  assign cu.ALUOp        = w_ctrl_out.alu_op;
  assign cu.ImmSrc       = w_ctrl_out.imm_src;
  assign cu.BrOp         = w_ctrl_out.br_op;
  assign cu.DMWr         = w_ctrl_out.dm_wr;
  assign cu.DMCtrl       = w_ctrl_out.dm_ctrl;
  assign cu.RUDataWrSrc  = w_ctrl_out.wb_src;
  assign cu.IllegalInstr = w_ctrl_out.illegal;
  assign cu.IllegalSeen  = illegal_seen_q;

endmodule

`default_nettype wire

// File: tb/tb_control_unit_decoder.sv
// ============================================================================
// tb_control_unit_decoder : directed and random decode checks against a
// table-style reference model, plus sticky-flag and async-reset checks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_unit_decoder_if cu ();

  control_unit_decoder dut (
    .clk (clk),
    .rst (rst),
    .cu  (cu.slave)
  );

  int errors = 0;
  int checks = 0;
  bit seen_exp = 1'b0;
  bit prev_ill = 1'b0;

  typedef struct {
    bit       ru;
    bit       asrc;
    bit       bsrc;
    bit [3:0] aluop;
    bit [2:0] imm;
    bit [4:0] br;
    bit       dmwr;
    bit [2:0] dmc;
    bit [1:0] wb;
    bit       ill;
  } exp_t;

  function automatic exp_t model(bit [6:0] op, bit [2:0] f3, bit [6:0] f7);
    exp_t e = '{default: 0};
    case (op)
      7'h33: begin e.ru = 1; e.aluop = {f7[5], f3}; end
      7'h13: begin e.ru = 1; e.bsrc = 1; e.aluop = (f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3}; end
      7'h03: begin e.ru = 1; e.bsrc = 1; e.dmc = f3; e.wb = 2'd1; end
      7'h23: begin e.bsrc = 1; e.imm = 3'd1; e.dmwr = 1; e.dmc = f3; end
      7'h63: begin e.asrc = 1; e.bsrc = 1; e.imm = 3'd5; e.br = 5'd8 + 5'(f3); end
      7'h67: begin e.ru = 1; e.bsrc = 1; e.br = 5'd16; e.wb = 2'd2; end
      7'h6f: begin e.ru = 1; e.asrc = 1; e.bsrc = 1; e.imm = 3'd6; e.br = 5'd16; e.wb = 2'd2; end
      7'h37: begin e.ru = 1; e.bsrc = 1; e.aluop = 4'd9; e.imm = 3'd2; end
      7'h17: begin e.ru = 1; e.asrc = 1; e.bsrc = 1; e.imm = 3'd2; end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input string name, input bit [6:0] op, input bit [2:0] f3, input bit [6:0] f7);
    exp_t e;
    cu.OpCode = op;
    cu.Funct3 = f3;
    cu.Funct7 = f7;
    e = model(op, f3, f7);
    @(posedge clk);
    #1;
`ifdef CU_OUTPUT_REG_EN
    seen_exp = seen_exp | prev_ill;
    prev_ill = e.ill;
`else
    seen_exp = seen_exp | e.ill;
`endif
    chk({name, "/RUWr"},         32'(cu.RUWr),         32'(e.ru));
    chk({name, "/ALUASrc"},      32'(cu.ALUASrc),      32'(e.asrc));
    chk({name, "/ALUBSrc"},      32'(cu.ALUBSrc),      32'(e.bsrc));
    chk({name, "/ALUOp"},        32'(cu.ALUOp),        32'(e.aluop));
    chk({name, "/ImmSrc"},       32'(cu.ImmSrc),       32'(e.imm));
    chk({name, "/BrOp"},         32'(cu.BrOp),         32'(e.br));
    chk({name, "/DMWr"},         32'(cu.DMWr),         32'(e.dmwr));
    chk({name, "/DMCtrl"},       32'(cu.DMCtrl),       32'(e.dmc));
    chk({name, "/RUDataWrSrc"},  32'(cu.RUDataWrSrc),  32'(e.wb));
    chk({name, "/IllegalInstr"}, 32'(cu.IllegalInstr), 32'(e.ill));
    chk({name, "/IllegalSeen"},  32'(cu.IllegalSeen),  32'(seen_exp));
  endtask

  bit [6:0] legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6f, 7'h37, 7'h17};

  initial begin
    bit [6:0] op;
    bit [2:0] f3;
    bit [6:0] f7;
    int pick;

    rst = 1'b1;
    cu.OpCode = 7'h7f;
    cu.Funct3 = 3'd0;
    cu.Funct7 = 7'd0;
    @(posedge clk);
    #1;
    chk("reset/IllegalSeen", 32'(cu.IllegalSeen), 32'd0);
`ifndef CU_OUTPUT_REG_EN
    chk("reset/IllegalInstr", 32'(cu.IllegalInstr), 32'd1);
`endif
    rst = 1'b0;

    step("SUB",   7'h33, 3'b000, 7'h20);
    step("SRA",   7'h33, 3'b101, 7'h20);
    step("AND",   7'h33, 3'b111, 7'h00);
    step("ADDI",  7'h13, 3'b000, 7'h20);
    step("SRAI",  7'h13, 3'b101, 7'h20);
    step("LHU",   7'h03, 3'b101, 7'h00);
    step("SW",    7'h23, 3'b010, 7'h00);
    step("BLTU",  7'h63, 3'b110, 7'h00);
    step("JAL",   7'h6f, 3'b000, 7'h00);
    step("JALR",  7'h67, 3'b000, 7'h00);
    step("LUI",   7'h37, 3'b011, 7'h55);
    step("AUIPC", 7'h17, 3'b000, 7'h00);
    step("ILL",   7'h7f, 3'b000, 7'h00);
    step("ADD_after_ill", 7'h33, 3'b000, 7'h00);
    step("LW_after_ill",  7'h03, 3'b010, 7'h00);

    // Asynchronous reset pulse in the middle of a cycle.
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst/IllegalSeen", 32'(cu.IllegalSeen), 32'd0);
    cu.OpCode = 7'h7f;
    @(posedge clk);
    #1;
    chk("rst_wins/IllegalSeen", 32'(cu.IllegalSeen), 32'd0);
    rst = 1'b0;
    seen_exp = 1'b0;
    prev_ill = 1'b0;

    step("post_rst_legal", 7'h13, 3'b001, 7'h00);

    for (int i = 0; i < 250; i++) begin
      pick = $urandom_range(0, 11);
      if (pick < 9) op = legal_ops[pick];
      else          op = 7'($urandom);
      f3 = 3'($urandom);
      f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom);
      step($sformatf("rand%0d_op%02h", i, op), op, f3, f7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_unit_decoder.md
# control_unit_decoder

Main instruction decoder of the single-cycle RV32I core. Combinational decode of OpCode/Funct3/Funct7 into datapath controls: register-file write, ALU operand select and operation, immediate format, branch operation, data-memory write/size, and write-back source. One clocked element, a sticky illegal-instruction flag, sits beside the decoder. An optional output register stage is also clocked.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- OpCode  in  7  instr[6:0]
- Funct3  in  3  instr[14:12]
- Funct7  in  7  instr[31:25]
- RUWr  out  1  register-file write enable
- ALUASrc  out  1  ALU A: 0=rs1, 1=PC
- ALUBSrc  out  1  ALU B: 0=rs2, 1=immediate
- ALUOp  out  4  ALU operation
- ImmSrc  out  3  immediate format
- BrOp  out  5  branch operation
- DMWr  out  1  data-memory write enable
- DMCtrl  out  3  memory access size/sign (Funct3 encoding)
- RUDataWrSrc  out  2  write-back: 00=ALU, 01=memory, 10=PC+4
- IllegalInstr  out  1  current OpCode unsupported (combinational)
- IllegalSeen  out  1  sticky flag, set once any illegal OpCode is sampled

## Operation
- ALUOp codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, PASS_B 1001.
- ImmSrc codes: I 000, S 001, U 010, B 101, J 110.
- BrOp codes: 00000 no branch; {2'b01,Funct3} conditional; 10000 unconditional jump.
- Decode by OpCode. Signals not listed are 0.
  - R 0110011: RUWr=1; ALUOp={Funct7[5],Funct3}.
  - I-ALU 0010011: RUWr=1, ALUBSrc=1. ALUOp={Funct7[5],Funct3} when Funct3=101; otherwise {0,Funct3}. ADDI with imm[10]=1 must not become SUB.
  - Load 0000011: RUWr=1, ALUBSrc=1, ADD, ImmSrc=000, DMCtrl=Funct3, RUDataWrSrc=01.
  - Store 0100011: ALUBSrc=1, ADD, ImmSrc=001, DMWr=1, DMCtrl=Funct3.
  - Branch 1100011: ALUASrc=1, ALUBSrc=1, ADD, ImmSrc=101, BrOp={01,Funct3}.
  - JALR 1100111: RUWr=1, ALUBSrc=1, ADD, ImmSrc=000, BrOp=10000, RUDataWrSrc=10.
  - JAL 1101111: RUWr=1, ALUASrc=1, ALUBSrc=1, ADD, ImmSrc=110, BrOp=10000, RUDataWrSrc=10.
  - LUI 0110111: RUWr=1, ALUBSrc=1, PASS_B, ImmSrc=010.
  - AUIPC 0010111: RUWr=1, ALUASrc=1, ALUBSrc=1, ADD, ImmSrc=010.
- Any other OpCode:
  - All control outputs 0: safe NOP, no register or memory write, no branch.
  - IllegalInstr=1.
- Funct3/Funct7 are not validated inside a legal OpCode class. The decode rules above apply unchanged.

## Timing
- Decode is purely combinational, zero latency; outputs are valid within the same cycle as the inputs.
- IllegalSeen:
  - Set on the rising clk edge when IllegalInstr=1.
  - Holds until rst.
  - rst asserted (asynchronously, any time) forces it to 0 immediately.
  - If rst and an illegal OpCode coincide, rst wins.

## Configuration
- CU_OUTPUT_REG_EN defined:
  - All decode outputs (RUWr…RUDataWrSrc, IllegalInstr) pass through one register stage on clk, giving 1-cycle latency.
  - rst forces them to the NOP value (all 0).
  - IllegalSeen is set from the registered IllegalInstr.
- CU_OUTPUT_REG_EN undefined: decode outputs are combinational, as above.

## Structure
- Shared package rv_pkg holds:
  - opcode localparams;
  - ALUOp, ImmSrc, BrOp and RUDataWrSrc encodings (typedef enums);
  - funct3 constants.
- One sub-module, alu_decoder: computes ALUOp from the opcode class, Funct3 and Funct7[5].

## Test plan
- R-type sweep: SUB (Funct3=000, Funct7=0100000) -> ALUOp=1000, RUWr=1, ALUBSrc=0. SRA -> 1101. AND -> 0111.
- I-type: ADDI with Funct7=0100000 -> ALUOp=0000, ALUBSrc=1. SRAI (Funct3=101, Funct7=0100000) -> 1101.
- Memory:
  - LHU -> DMCtrl=101, RUDataWrSrc=01, RUWr=1.
  - SW -> DMWr=1, RUWr=0, ImmSrc=001, DMCtrl=010.
- Branch/jump:
  - BLTU -> BrOp=01110, ImmSrc=101, ALUASrc=1.
  - JAL -> BrOp=10000, ImmSrc=110, RUDataWrSrc=10.
  - JALR -> ALUASrc=0, ImmSrc=000.
- Upper immediates: LUI -> ALUOp=1001, ImmSrc=010. AUIPC -> ALUOp=0000, ALUASrc=1.
- Illegal opcode 1111111:
  - All controls 0, IllegalInstr=1.
  - IllegalSeen=1 after the next clk edge and stays 1 under legal opcodes.
  - Async rst pulse mid-cycle clears it immediately.
